regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default rv32i_pkg::XLEN (32), sets the data width.
REQ-002 Parameter REG_COUNT, default rv32i_pkg::REG_COUNT (32), sets the register count; legal values are powers of two of at least 2.
REQ-003 Parameter NUM_RD, default 2, sets the number of read ports (1..4).
REQ-004 Parameter NUM_WR, default 2, sets the number of write ports (1..2).
REQ-005 Parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-006 Local constant AW = $clog2(REG_COUNT).
REQ-007 clk  in  1  sole clock; rising edge.
REQ-008 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-009 rd_addr  in  NUM_RD x AW  read addresses.
REQ-010 rdata  out  NUM_RD x XLEN  read data.
REQ-011 rd_busy  out  NUM_RD  addressed register awaits writeback.
REQ-012 wr_en  in  NUM_WR  write strobes.
REQ-013 wr_addr  in  NUM_WR x AW  write addresses.
REQ-014 wdata  in  NUM_WR x XLEN  write data.
REQ-015 alloc_en  in  1  mark a destination register pending.
REQ-016 alloc_addr  in  AW  register to mark.
REQ-017 busy_count  out  AW+1  number of pending registers.

Function
REQ-018 Reads are combinational; address 0 always returns zero and rd_busy=0.
REQ-019 A write with wr_en=1 and a nonzero address updates the register on the rising edge; writes to address 0 are discarded.
REQ-020 When two write ports target the same nonzero address in one cycle, port NUM_WR-1 wins.
REQ-021 With BYPASS=1, a read matching an active same-cycle write returns that wdata, using the REQ-020 priority; with BYPASS=0, it returns the stored value.
REQ-022 Each register has a busy bit: alloc_en sets it at the edge; any write to that address clears it at the edge.
REQ-023 If allocation and a write hit the same address in one cycle, set wins and the register stays busy.
REQ-024 alloc_addr=0 is ignored; register 0 is never busy.
REQ-025 rd_busy = busy bit AND NOT (BYPASS=1 AND an active write to that address this cycle).
REQ-026 busy_count is registered and equals the popcount of the busy bits after each edge; it changes by at most +1 or -NUM_WR per cycle.
REQ-027 Re-allocating an already-busy register leaves busy_count unchanged.
REQ-028 busy_count saturates at REG_COUNT-1 and never wraps.

Reset
REQ-029 On aresetn=0, all registers, busy bits and busy_count clear to 0 immediately, without waiting for a clock edge.
REQ-030 While aresetn=0, rdata reads 0, except that BYPASS forwarding still applies to wdata.
REQ-031 Writes and allocations in progress at reset assertion are lost; operation resumes on the first rising edge after deassertion.

Structure
REQ-032 rv32i_pkg holds XLEN, REG_COUNT and REG_ADDR_WIDTH, plus new typedefs reg_addr_t and xlen_t; no package changes beyond these.
REQ-033 The busy bits and busy_count live in one sub-module, regfile_scoreboard (inputs: alloc and clear vectors; outputs: busy vector and count).
REQ-034 The storage array and bypass muxing stay in regfile_mp.

Verification
REQ-035 Reset then read all 32 addresses on both ports -> rdata=0, rd_busy=0, busy_count=0.
REQ-036 Write 0xDEADBEEF to x5 on port0 while reading x5 in the same cycle -> with BYPASS=1, rdata=0xDEADBEEF that cycle; with BYPASS=0, rdata=0 that cycle and 0xDEADBEEF the next.
REQ-037 Ports 0 and 1 write x7 with 0x11 and 0x22 in the same cycle -> x7 reads 0x22.
REQ-038 Allocate x3, x4 and x0 over three cycles -> busy_count=2; writeback x3 -> count 1; allocate x4 and write x4 in the same cycle -> x4 stays busy, count 1.
REQ-039 Write x0 with 0xFFFFFFFF; allocate x0 -> x0 reads 0, not busy, count unchanged.
REQ-040 Assert aresetn mid-sequence between edges with x9=0xA5 and busy -> outputs clear immediately; after deassertion, x9 reads 0 and busy_count=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I architectural constants and basic types.
//   XLEN           - integer register width
//   REG_COUNT      - number of architectural integer registers
//   REG_ADDR_WIDTH - bits needed to address one register
//   reg_addr_t     - register address type
//   xlen_t         - register data type
package rv32i_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_COUNT      = 32;
    localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_COUNT);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]           xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-writeback bits and their count.
//   clk        in   clock, rising edge
//   aresetn    in   asynchronous active-low reset
//   alloc_vec  in   N_REGS one-hot-or-zero: registers to mark pending
//   clr_vec    in   N_REGS: registers written back this cycle
//   busy       out  N_REGS pending bits (bit 0 always 0)
//   busy_count out  registered popcount of busy
module regfile_scoreboard
    import rv32i_pkg::*;
#(
    parameter  int unsigned N_REGS = REG_COUNT,
    localparam int unsigned CW     = $clog2(N_REGS) + 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [N_REGS-1:0] alloc_vec,
    input  logic [N_REGS-1:0] clr_vec,
    output logic [N_REGS-1:0] busy,
    output logic [CW-1:0]     busy_count
);

    logic [N_REGS-1:0] busy_next;
    logic [CW-1:0]     count_next;

    always_comb begin
        // Set after clear: an allocation wins over a same-cycle writeback.
        busy_next    = (busy & ~clr_vec) | alloc_vec;
        busy_next[0] = 1'b0;

        count_next = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            count_next = count_next + CW'(busy_next[i]);
        end
        // Bit 0 is never set, so this bound already holds; the clamp keeps
        // the no-wrap guarantee independent of that detail.
        if (count_next > CW'(N_REGS - 1)) begin
            count_next = CW'(N_REGS - 1);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported integer register file with write-to-read bypass
// and a pending-writeback scoreboard.
//   clk        in   clock, rising edge
//   aresetn    in   asynchronous active-low reset
//   rd_addr    in   NUM_RD x AW read addresses
//   rdata      out  NUM_RD x XLEN combinational read data (x0 reads 0)
//   rd_busy    out  NUM_RD addressed register awaits writeback
//   wr_en      in   NUM_WR write strobes
//   wr_addr    in   NUM_WR x AW write addresses (x0 writes discarded)
//   wdata      in   NUM_WR x XLEN write data; highest port wins on conflict
//   alloc_en   in   mark alloc_addr pending
//   alloc_addr in   AW register to mark
//   busy_count out  AW+1 number of pending registers (registered)
module regfile_mp #(
    parameter  int unsigned XLEN      = rv32i_pkg::XLEN,
    parameter  int unsigned REG_COUNT = rv32i_pkg::REG_COUNT,
    parameter  int unsigned NUM_RD    = 2,
    parameter  int unsigned NUM_WR    = 2,
    parameter  int unsigned BYPASS    = 1,
    localparam int unsigned AW        = $clog2(REG_COUNT)
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]  rdata,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]  wdata,
    input  logic                         alloc_en,
    input  logic [AW-1:0]                alloc_addr,
    output logic [AW:0]                  busy_count
);

    logic [XLEN-1:0]      regs [REG_COUNT];
    logic [REG_COUNT-1:0] alloc_vec;
    logic [REG_COUNT-1:0] clr_vec;
    logic [REG_COUNT-1:0] busy_vec;

    // Ascending port order makes the last port's write the one that sticks.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            regs <= '{default: '0};
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w] != '0)) begin
                    regs[wr_addr[w]] <= wdata[w];
                end
            end
        end
    end

    always_comb begin
        rdata   = '0;
        rd_busy = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            logic            hit;
            logic [XLEN-1:0] fwd;
            hit = 1'b0;
            fwd = '0;
            // Later ports overwrite earlier matches, mirroring write priority.
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if ((BYPASS == 1) && wr_en[w] && (wr_addr[w] == rd_addr[r])) begin
                    hit = 1'b1;
                    fwd = wdata[w];
                end
            end
            if (rd_addr[r] == '0) begin
                rdata[r]   = '0;
                rd_busy[r] = 1'b0;
            end else begin
                rdata[r]   = hit ? fwd : regs[rd_addr[r]];
                rd_busy[r] = busy_vec[rd_addr[r]] & ~hit;
            end
        end
    end

    always_comb begin
        alloc_vec = '0;
        clr_vec   = '0;
        if (alloc_en) begin
            alloc_vec[alloc_addr] = 1'b1;
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                clr_vec[wr_addr[w]] = 1'b1;
            end
        end
    end

    regfile_scoreboard #(
        .N_REGS (REG_COUNT)
    ) u_scoreboard (
        .clk        (clk),
        .aresetn    (aresetn),
        .alloc_vec  (alloc_vec),
        .clr_vec    (clr_vec),
        .busy       (busy_vec),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic                 clk;
    logic                 aresetn;
    logic [1:0][4:0]      rd_addr;
    logic [1:0]           wr_en;
    logic [1:0][4:0]      wr_addr;
    logic [1:0][31:0]     wdata;
    logic                 alloc_en;
    logic [4:0]           alloc_addr;

    logic [1:0][31:0]     rdata_b,   rdata_nb;
    logic [1:0]           rd_busy_b, rd_busy_nb;
    logic [5:0]           count_b,   count_nb;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .XLEN      (32),
        .REG_COUNT (32),
        .NUM_RD    (2),
        .NUM_WR    (2),
        .BYPASS    (1)
    ) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .rd_addr    (rd_addr),
        .rdata      (rdata_b),
        .rd_busy    (rd_busy_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wdata      (wdata),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_count (count_b)
    );

    regfile_mp #(
        .XLEN      (32),
        .REG_COUNT (32),
        .NUM_RD    (2),
        .NUM_WR    (2),
        .BYPASS    (0)
    ) dut_nb (
        .clk        (clk),
        .aresetn    (aresetn),
        .rd_addr    (rd_addr),
        .rdata      (rdata_nb),
        .rd_busy    (rd_busy_nb),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wdata      (wdata),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_count (count_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wdata      = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
    endtask

    initial begin
        aresetn = 1'b0;
        rd_addr = '0;
        idle();
        #12;
        check("reset_count_b",  32'(count_b),  32'd0);
        check("reset_count_nb", 32'(count_nb), 32'd0);
        @(posedge clk);
        #1 aresetn = 1'b1;

        // All addresses read zero and not busy after reset.
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(31 - a);
            #1;
            check("rst_rd0",   rdata_b[0],       32'd0);
            check("rst_rd1",   rdata_b[1],       32'd0);
            check("rst_busy",  32'(rd_busy_b),   32'd0);
            check("rst_rd_nb", rdata_nb[0],      32'd0);
        end
        tick();

        // Same-cycle write and read of x5.
        wr_en = 2'b01; wr_addr[0] = 5'd5; wdata[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
        #1;
        check("byp_x5",      rdata_b[0],  32'hDEADBEEF);
        check("nobyp_x5",    rdata_nb[0], 32'd0);
        tick();
        idle();
        #1;
        check("x5_next_b",   rdata_b[0],  32'hDEADBEEF);
        check("x5_next_nb",  rdata_nb[0], 32'hDEADBEEF);

        // Two ports write x7: port 1 wins, also on the bypass path.
        wr_en = 2'b11; wr_addr[0] = 5'd7; wr_addr[1] = 5'd7;
        wdata[0] = 32'h11; wdata[1] = 32'h22; rd_addr[1] = 5'd7;
        #1;
        check("byp_x7_prio", rdata_b[1],  32'h22);
        check("nobyp_x7",    rdata_nb[1], 32'd0);
        tick();
        idle();
        #1;
        check("x7_b",        rdata_b[1],  32'h22);
        check("x7_nb",       rdata_nb[1], 32'h22);

        // Scoreboard: allocate x3, x4, x0.
        alloc_en = 1'b1; alloc_addr = 5'd3;
        tick();
        check("cnt_alloc3", 32'(count_b), 32'd1);
        alloc_addr = 5'd4;
        tick();
        check("cnt_alloc4", 32'(count_b), 32'd2);
        alloc_addr = 5'd0;
        tick();
        check("cnt_alloc0", 32'(count_b), 32'd2);
        idle();
        rd_addr[0] = 5'd3; rd_addr[1] = 5'd0;
        #1;
        check("busy_x3_x0_b",  32'(rd_busy_b),  32'b01);
        check("busy_x3_x0_nb", 32'(rd_busy_nb), 32'b01);

        // Writeback x3: bypass hides busy during the write cycle.
        wr_en = 2'b01; wr_addr[0] = 5'd3; wdata[0] = 32'h33;
        #1;
        check("wb_busy_b",  32'(rd_busy_b[0]),  32'd0);
        check("wb_busy_nb", 32'(rd_busy_nb[0]), 32'd1);
        check("wb_data_b",  rdata_b[0],         32'h33);
        tick();
        idle();
        #1;
        check("cnt_wb3",     32'(count_b),      32'd1);
        check("x3_notbusy",  32'(rd_busy_b[0]), 32'd0);
        check("x3_data_nb",  rdata_nb[0],       32'h33);

        // Allocate and write x4 together: stays busy.
        alloc_en = 1'b1; alloc_addr = 5'd4;
        wr_en = 2'b10; wr_addr[1] = 5'd4; wdata[1] = 32'h44;
        tick();
        idle();
        rd_addr[0] = 5'd4;
        #1;
        check("x4_busy",    32'(rd_busy_b[0]),  32'd1);
        check("x4_busy_nb", 32'(rd_busy_nb[0]), 32'd1);
        check("cnt_x4",     32'(count_b),       32'd1);
        check("x4_data",    rdata_b[0],         32'h44);

        // x0 ignores writes and allocation.
        wr_en = 2'b01; wr_addr[0] = 5'd0; wdata[0] = 32'hFFFFFFFF; rd_addr[0] = 5'd0;
        #1;
        check("x0_byp", rdata_b[0], 32'd0);
        tick();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd0;
        tick();
        idle();
        #1;
        check("x0_rd_b",   rdata_b[0],        32'd0);
        check("x0_rd_nb",  rdata_nb[0],       32'd0);
        check("x0_busy",   32'(rd_busy_b[0]), 32'd0);
        check("x0_cnt",    32'(count_b),      32'd1);

        // Fill every register; x4 is already busy so its re-allocation is a no-op.
        alloc_en = 1'b1;
        for (int i = 1; i < 32; i++) begin
            alloc_addr = 5'(i);
            tick();
            check("cnt_fill", 32'(count_b), (i < 4) ? 32'(i + 1) : 32'(i));
        end
        alloc_addr = 5'd31;
        tick();
        check("cnt_sat",    32'(count_b),  32'd31);
        check("cnt_sat_nb", 32'(count_nb), 32'd31);
        idle();

        // Two writebacks in one cycle drop the count by two.
        wr_en = 2'b11; wr_addr[0] = 5'd10; wr_addr[1] = 5'd20;
        wdata[0] = 32'h10; wdata[1] = 32'h20;
        tick();
        idle();
        rd_addr[0] = 5'd10; rd_addr[1] = 5'd20;
        #1;
        check("cnt_dual_wb", 32'(count_b),   32'd29);
        check("dual_wb_bsy", 32'(rd_busy_b), 32'b00);

        // x9 = 0xA5 and busy, then reset between edges.
        wr_en = 2'b01; wr_addr[0] = 5'd9; wdata[0] = 32'hA5;
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        idle();
        rd_addr[0] = 5'd9;
        #1;
        check("x9_data",  rdata_b[0],        32'hA5);
        check("x9_busy",  32'(rd_busy_b[0]), 32'd1);
        check("x9_cnt",   32'(count_b),      32'd29);
        #1 aresetn = 1'b0;
        #1;
        check("arst_data_b",  rdata_b[0],        32'd0);
        check("arst_data_nb", rdata_nb[0],       32'd0);
        check("arst_busy",    32'(rd_busy_b[0]), 32'd0);
        check("arst_cnt_b",   32'(count_b),      32'd0);
        check("arst_cnt_nb",  32'(count_nb),     32'd0);

        // Forwarding still applies during reset; the write itself is lost.
        wr_en = 2'b01; wr_addr[0] = 5'd9; wdata[0] = 32'h77;
        alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        check("arst_byp_b",  rdata_b[0],  32'h77);
        check("arst_byp_nb", rdata_nb[0], 32'd0);
        tick();
        check("arst_edge_nb", rdata_nb[0], 32'd0);
        idle();
        aresetn = 1'b1;
        tick();
        check("post_rst_x9",   rdata_b[0],        32'd0);
        check("post_rst_busy", 32'(rd_busy_b[0]), 32'd0);
        check("post_rst_cnt",  32'(count_b),      32'd0);

        // Normal operation resumes.
        wr_en = 2'b01; wr_addr[0] = 5'd9; wdata[0] = 32'h5A;
        tick();
        idle();
        #1;
        check("resume_x9_b",  rdata_b[0],  32'h5A);
        check("resume_x9_nb", rdata_nb[0], 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
